// File: rtl/pe_array_seq.sv
// pe_array_seq: block-matching search sequencer for a PE_array.
// Per search it loads a 16-word current block, then for each horizontal
// offset h it loads 4 reference row-groups and sweeps all vertical offsets v,
// shifting in one new reference row per step. The FSM holds state and
// counters in any cycle where mem_ready is low.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   start               one-cycle search request (ignored while busy)
//   mem_ready           memory data valid this cycle; low stalls the walk
//   busy, done          search in progress / one-cycle completion pulse
//   in_curr_enable      current-block write enable
//   CB_select           current-buffer ping-pong select (toggles per search)
//   abs_Control         00 hold, 01 compute
//   change_ref          new reference column pulse
//   ref_input_Control   00 hold, 01 load 8 rows, 10 shift 1 row
//   cb_addr             current-block word address
//   ref_row_addr        first reference row fetched
//   ref_col_addr        reference column (= h)
//   abs_valid, mv_x, mv_y  registered compute strobe with its (h, v) tag
module pe_array_seq #(
    parameter int unsigned SEARCH_H = 16,
    parameter int unsigned SEARCH_V = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mem_ready,
    output logic       busy,
    output logic       done,
    output logic       in_curr_enable,
    output logic       CB_select,
    output logic [1:0] abs_Control,
    output logic       change_ref,
    output logic [1:0] ref_input_Control,
    output logic [3:0] cb_addr,
    output logic [6:0] ref_row_addr,
    output logic [5:0] ref_col_addr,
    output logic       abs_valid,
    output logic [5:0] mv_x,
    output logic [5:0] mv_y
);

    localparam int unsigned CNT_W  = 6;
    localparam int unsigned ROW_W  = 7;
    localparam int unsigned WORD_W = 4;
    localparam int unsigned K_W    = 2;

    localparam logic [CNT_W-1:0]  H_LAST    = CNT_W'(SEARCH_H - 1);
    localparam logic [CNT_W-1:0]  V_LAST    = CNT_W'(SEARCH_V - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(15);
    localparam logic [K_W-1:0]    K_LAST    = K_W'(3);
    localparam logic [ROW_W-1:0]  ROW_SHIFT = ROW_W'(32);

    localparam logic [1:0] ABS_HOLD    = 2'b00;
    localparam logic [1:0] ABS_COMPUTE = 2'b01;
    localparam logic [1:0] REF_HOLD    = 2'b00;
    localparam logic [1:0] REF_LOAD8   = 2'b01;
    localparam logic [1:0] REF_SHIFT1  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CB,
        LOAD_REF,
        SEARCH,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic               cb_sel_q, cb_sel_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [CNT_W-1:0]   h_q, h_d;
    logic [CNT_W-1:0]   v_q, v_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               abs_valid_q;
    logic [CNT_W-1:0]   mv_x_q, mv_y_q;

    // State, counters and the registered compute tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cb_sel_q    <= 1'b0;
            word_q      <= '0;
            k_q         <= '0;
            h_q         <= '0;
            v_q         <= '0;
            row_q       <= '0;
            abs_valid_q <= 1'b0;
            mv_x_q      <= '0;
            mv_y_q      <= '0;
        end else begin
            state_q     <= state_d;
            cb_sel_q    <= cb_sel_d;
            word_q      <= word_d;
            k_q         <= k_d;
            h_q         <= h_d;
            v_q         <= v_d;
            row_q       <= row_d;
            abs_valid_q <= (abs_Control == ABS_COMPUTE);
            mv_x_q      <= h_q;
            mv_y_q      <= v_q;
        end
    end

    // Next-state, counter updates and PE_array controls; a low mem_ready
    // leaves every default (hold) in place
    always_comb begin
        state_d           = state_q;
        cb_sel_d          = cb_sel_q;
        word_d            = word_q;
        k_d               = k_q;
        h_d               = h_q;
        v_d               = v_q;
        row_d             = row_q;
        busy              = 1'b1;
        done              = 1'b0;
        in_curr_enable    = 1'b0;
        change_ref        = 1'b0;
        abs_Control       = ABS_HOLD;
        ref_input_Control = REF_HOLD;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d  = LOAD_CB;
                    cb_sel_d = ~cb_sel_q;
                    word_d   = '0;
                end
            end
            LOAD_CB: begin
                if (mem_ready) begin
                    in_curr_enable = 1'b1;
                    if (word_q == WORD_LAST) begin
                        state_d = LOAD_REF;
                        h_d     = '0;
                        k_d     = '0;
                    end else begin
                        word_d = word_q + WORD_W'(1);
                    end
                end
            end
            LOAD_REF: begin
                if (mem_ready) begin
                    ref_input_Control = REF_LOAD8;
                    change_ref        = (k_q == '0);
                    row_d             = ROW_W'({k_q, 3'b000});
                    if (k_q == K_LAST) begin
                        state_d = SEARCH;
                        v_d     = '0;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            SEARCH: begin
                if (mem_ready) begin
                    abs_Control = ABS_COMPUTE;
                    if (v_q != V_LAST) begin
                        // Next vertical offset needs one more reference row
                        ref_input_Control = REF_SHIFT1;
                        row_d             = ROW_SHIFT + ROW_W'(v_q);
                        v_d               = v_q + CNT_W'(1);
                    end else if (h_q != H_LAST) begin
                        h_d     = h_q + CNT_W'(1);
                        k_d     = '0;
                        state_d = LOAD_REF;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign CB_select    = cb_sel_q;
    assign cb_addr      = word_q;
    assign ref_row_addr = row_d;
    assign ref_col_addr = h_q;
    assign abs_valid    = abs_valid_q;
    assign mv_x         = mv_x_q;
    assign mv_y         = mv_y_q;

endmodule

// File: tb/tb_pe_array_seq.sv
// Directed bench for pe_array_seq: default-size instance plus a 1x1 instance.
module tb_pe_array_seq;

    logic clk;
    logic rst_n;
    logic start;
    logic mem_ready;
    logic sel;

    logic       d1_busy, d1_done, d1_ice, d1_cbs, d1_cref, d1_av;
    logic [1:0] d1_absc, d1_ric;
    logic [3:0] d1_cba;
    logic [6:0] d1_row;
    logic [5:0] d1_col, d1_mvx, d1_mvy;

    logic       d2_busy, d2_done, d2_ice, d2_cbs, d2_cref, d2_av;
    logic [1:0] d2_absc, d2_ric;
    logic [3:0] d2_cba;
    logic [6:0] d2_row;
    logic [5:0] d2_col, d2_mvx, d2_mvy;

    logic start1, start2;
    assign start1 = start & ~sel;
    assign start2 = start & sel;

    pe_array_seq u_dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .mem_ready(mem_ready),
        .busy(d1_busy), .done(d1_done), .in_curr_enable(d1_ice),
        .CB_select(d1_cbs), .abs_Control(d1_absc), .change_ref(d1_cref),
        .ref_input_Control(d1_ric), .cb_addr(d1_cba), .ref_row_addr(d1_row),
        .ref_col_addr(d1_col), .abs_valid(d1_av), .mv_x(d1_mvx), .mv_y(d1_mvy)
    );

    pe_array_seq #(.SEARCH_H(1), .SEARCH_V(1)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .start(start2), .mem_ready(mem_ready),
        .busy(d2_busy), .done(d2_done), .in_curr_enable(d2_ice),
        .CB_select(d2_cbs), .abs_Control(d2_absc), .change_ref(d2_cref),
        .ref_input_Control(d2_ric), .cb_addr(d2_cba), .ref_row_addr(d2_row),
        .ref_col_addr(d2_col), .abs_valid(d2_av), .mv_x(d2_mvx), .mv_y(d2_mvy)
    );

    // Selected instance view
    logic       s_busy, s_done, s_ice, s_cbs, s_cref, s_av;
    logic [1:0] s_absc, s_ric;
    logic [3:0] s_cba;
    logic [6:0] s_row;
    logic [5:0] s_col, s_mvx, s_mvy;
    logic [38:0] s_outs;

    assign s_busy = sel ? d2_busy : d1_busy;
    assign s_done = sel ? d2_done : d1_done;
    assign s_ice  = sel ? d2_ice  : d1_ice;
    assign s_cbs  = sel ? d2_cbs  : d1_cbs;
    assign s_cref = sel ? d2_cref : d1_cref;
    assign s_av   = sel ? d2_av   : d1_av;
    assign s_absc = sel ? d2_absc : d1_absc;
    assign s_ric  = sel ? d2_ric  : d1_ric;
    assign s_cba  = sel ? d2_cba  : d1_cba;
    assign s_row  = sel ? d2_row  : d1_row;
    assign s_col  = sel ? d2_col  : d1_col;
    assign s_mvx  = sel ? d2_mvx  : d1_mvx;
    assign s_mvy  = sel ? d2_mvy  : d1_mvy;
    assign s_outs = {s_busy, s_done, s_ice, s_cbs, s_absc, s_cref, s_ric,
                     s_cba, s_row, s_col, s_av, s_mvx, s_mvy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One search: optional stall window, optional mid-search start, optional
    // reset abort. Cycle c is the c-th cycle after the edge that accepts start.
    task automatic run(input string name, input bit use_small, input int h, input int v,
                       input int stall_lo, input int stall_hi, input int start_at,
                       input int abort_at, input logic exp_cb, input int exp_done,
                       input int exp_probe);
        int ice_n, cref_n, valid_n, shift_n, raster_err, addr_err, stall_act;
        int done_cyc, probe_cyc, ld_idx, ctrl_idx, cb_err, extra_done, busy_after;
        ice_n = 0; cref_n = 0; valid_n = 0; shift_n = 0; raster_err = 0;
        addr_err = 0; stall_act = 0; done_cyc = 0; probe_cyc = 0;
        ld_idx = 0; ctrl_idx = 0; cb_err = 0; extra_done = 0; busy_after = 0;
        sel = use_small;
        @(negedge clk);
        for (int i = 0; i < 8 && s_busy; i++) @(negedge clk);
        mem_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 3000; c++) begin
            mem_ready = !(c >= stall_lo && c <= stall_hi);
            start = (c == start_at);
            @(negedge clk);
            if (c == abort_at) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                check({name, ":reset_outs"}, 64'(s_outs), 64'(0));
                mem_ready = 1'b1;
                return;
            end
            if (s_cbs !== exp_cb) cb_err++;
            if (!mem_ready && (s_ice || s_cref || s_absc != 2'b00 || s_ric != 2'b00))
                stall_act++;
            if (s_ice) begin
                if (s_cba != 4'(ice_n)) addr_err++;
                ice_n++;
            end
            if (s_ric == 2'b01) begin
                if (s_row != 7'(8 * (ld_idx % 4))) addr_err++;
                if (s_cref != ((ld_idx % 4) == 0)) addr_err++;
                ld_idx++;
            end
            if (s_cref) cref_n++;
            if (s_absc == 2'b01) begin
                if (s_col != 6'(ctrl_idx / v)) addr_err++;
                if ((ctrl_idx % v) < v - 1) begin
                    if (s_ric != 2'b10 || s_row != 7'(32 + (ctrl_idx % v))) addr_err++;
                end else if (s_ric != 2'b00) begin
                    addr_err++;
                end
                ctrl_idx++;
            end
            if (s_ric == 2'b10) shift_n++;
            if (s_av) begin
                if (s_mvx != 6'(valid_n / v) || s_mvy != 6'(valid_n % v)) raster_err++;
                if (s_mvx == 6'd2 && s_mvy == 6'd5) probe_cyc = c;
                valid_n++;
            end
            if (s_done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (s_done) extra_done++;
            if (s_busy) busy_after++;
        end
        check({name, ":done_cycle"}, 64'(done_cyc), 64'(exp_done));
        check({name, ":ice_count"}, 64'(ice_n), 64'(16));
        check({name, ":change_ref_count"}, 64'(cref_n), 64'(h));
        check({name, ":abs_valid_count"}, 64'(valid_n), 64'(h * v));
        check({name, ":shift_count"}, 64'(shift_n), 64'(h * (v - 1)));
        check({name, ":raster_err"}, 64'(raster_err), 64'(0));
        check({name, ":addr_err"}, 64'(addr_err), 64'(0));
        check({name, ":stall_activity"}, 64'(stall_act), 64'(0));
        check({name, ":cb_select_err"}, 64'(cb_err), 64'(0));
        check({name, ":extra_done"}, 64'(extra_done), 64'(0));
        check({name, ":busy_after"}, 64'(busy_after), 64'(0));
        if (exp_probe != 0)
            check({name, ":probe_2_5_cycle"}, 64'(probe_cyc), 64'(exp_probe));
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        start = 1'b0;
        mem_ready = 1'b1;
        sel = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_outs", 64'(s_outs), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outs", 64'(s_outs), 64'(0));

        run("basic",    1'b0, 16, 16,  0,  0,   0,  0, 1'b1, 337,  0);
        run("b2b",      1'b0, 16, 16,  0,  0,   0,  0, 1'b0, 337,  0);
        run("stall",    1'b0, 16, 16, 66, 68,   0,  0, 1'b1, 340, 70);
        run("restart",  1'b0, 16, 16,  0,  0, 100,  0, 1'b0, 337,  0);
        run("abort",    1'b0, 16, 16,  0,  0,   0, 18, 1'b1,   0,  0);
        @(negedge clk);
        check("abort_hold_outs", 64'(s_outs), 64'(0));
        rst_n = 1'b1;
        run("post_rst", 1'b0, 16, 16,  0,  0,   0,  0, 1'b1, 337,  0);
        run("small",    1'b1,  1,  1,  0,  0,   0,  0, 1'b1,  22,  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_array_seq.md
PE_ARRAY_SEQ -- requirements
Module: pe_array_seq

Interface
REQ-001 The module SHALL have parameter SEARCH_H, default 16, meaning the number of horizontal search positions (legal 1..32).
REQ-002 The module SHALL have parameter SEARCH_V, default 16, meaning the number of vertical search positions (legal 1..32).
REQ-003 Port clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port start  input  1  one-cycle request to begin a block search.
REQ-006 Port mem_ready  input  1  current/reference memory data valid this cycle; low means stall.
REQ-007 Port busy  output  1  high from the accepted start through the DONE state.
REQ-008 Port done  output  1  one-cycle completion pulse.
REQ-009 Port in_curr_enable  output  1  PE_array current-block write enable.
REQ-010 Port CB_select  output  1  PE_array current-buffer ping-pong select.
REQ-011 Port abs_Control  output  2  PE_array mode: 00 hold, 01 compute.
REQ-012 Port change_ref  output  1  PE_array new-reference-column pulse.
REQ-013 Port ref_input_Control  output  2  PE_array reference input mode: 00 hold, 01 load 8 rows, 10 shift 1 row.
REQ-014 Port cb_addr  output  4  current-block read address, one 64-pixel word per address.
REQ-015 Port ref_row_addr  output  7  first reference row being fetched.
REQ-016 Port ref_col_addr  output  6  reference column, equal to the horizontal offset.
REQ-017 Port abs_valid  output  1  PE_array abs_outs valid for the tagged offset.
REQ-018 Port mv_x  output  6  horizontal offset tag aligned with abs_valid.
REQ-019 Port mv_y  output  6  vertical offset tag aligned with abs_valid.

Function
REQ-020 The FSM SHALL have exactly five states: IDLE, LOAD_CB, LOAD_REF, SEARCH, DONE.
REQ-021 IDLE -> LOAD_CB when start=1; start while busy=1 SHALL be ignored.
REQ-022 On the same edge that accepts start, CB_select SHALL toggle, and the new value SHALL be held for the whole search.
REQ-023 LOAD_CB: on each mem_ready=1 cycle, in_curr_enable=1 and cb_addr increments 0..15; after word 15, go to LOAD_REF with h=0.
REQ-024 LOAD_REF: on each mem_ready=1 cycle, ref_input_Control=01 and ref_row_addr=8*k for k=0..3; change_ref=1 only on the first cycle, k=0; after k=3, go to SEARCH with v=0.
REQ-025 SEARCH: on each mem_ready=1 cycle, abs_Control=01 with the current (h,v); ref_input_Control=10 and ref_row_addr=32+v when v<SEARCH_V-1, else 00.
REQ-026 After v=SEARCH_V-1: if h<SEARCH_H-1, then h increments and the FSM goes to LOAD_REF; otherwise it goes to DONE.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-028 Any cycle with mem_ready=0 in LOAD_CB, LOAD_REF or SEARCH SHALL freeze state and counters and drive in_curr_enable=0, change_ref=0, abs_Control=00, ref_input_Control=00.
REQ-029 abs_valid, mv_x and mv_y SHALL be registered copies of (abs_Control==01, h, v), one cycle later.
REQ-030 With no stalls, done SHALL assert exactly 17+SEARCH_H*(4+SEARCH_V) cycles after the start edge (337 at defaults).
REQ-031 All PE_array control outputs SHALL be 0 in IDLE and DONE, except CB_select.
REQ-032 The address outputs SHALL hold their last value when not in use.

Reset
REQ-033 While rst_n=0, all outputs and counters SHALL be 0 and the state SHALL be IDLE, including when reset arrives mid-search.
REQ-034 After rst_n rises, the first start SHALL set CB_select to 1.

Verification
REQ-035 Start at defaults, mem_ready=1 -> 16 in_curr_enable cycles, 16 change_ref pulses, 256 abs_valid pulses with (mv_x,mv_y) covering 0..15 x 0..15 in raster order (y fastest), done at cycle 337.
REQ-036 mem_ready=0 for 3 cycles inside SEARCH at h=2, v=5 -> no control activity during the stall, abs_valid for (2,5) delayed by 3, done at cycle 340.
REQ-037 start pulsed at cycle 100 of a search -> ignored; CB_select unchanged; a single done.
REQ-038 rst_n=0 during LOAD_REF -> all outputs 0 immediately; a new start completes normally with CB_select=1.
REQ-039 SEARCH_H=1, SEARCH_V=1 -> 1 abs_valid with (0,0), ref_input_Control never 10, done at cycle 22.
REQ-040 Two back-to-back searches -> CB_select is 1 for the first search and 0 for the second.
